inst_fetch_ctrl: RTL

//  Sequences the single-cycle core's instruction memory. After reset it owns a

---
 rtl/inst_fetch_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller for the single-cycle core.
// After reset it waits for a start pulse, then runs a loader phase that writes
// program words into instruction memory. It then runs a fetch loop that feeds
// a one-entry valid/ready buffer towards decode and applies branch/jump
// redirects. Misaligned or out-of-range redirects and loader overflow raise a
// sticky error and park the controller in HALT until the next reset.
module inst_fetch_ctrl #(
    parameter int                 ADDR_W    = 32,
    parameter int                 MEM_BYTES = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetchState_t;

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    fetchState_t       state, stateNext;
    logic [ADDR_W-1:0] pc, pcNext;
    logic [ADDR_W-1:0] ldPtr, ldPtrNext;
    logic [31:0]       instReg, instNext;
    logic [ADDR_W-1:0] instPcReg, instPcNext;
    logic              instValidReg, instValidNext;
    logic              errReg, errNext;

    logic              pcInRange;
    logic              ldInRange;
    logic              redirectBad;
    logic              bufferFree;

    assign pcInRange   = (pc < MEM_LIMIT);
    assign ldInRange   = (ldPtr < MEM_LIMIT);
    assign redirectBad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= MEM_LIMIT);
    assign bufferFree  = !instValidReg || inst_ready;

    assign inst       = instReg;
    assign inst_pc    = instPcReg;
    assign inst_valid = instValidReg;
    assign err        = errReg;

    // Next-state, datapath updates and memory-side outputs; every phase starts
    // from "hold everything, drive nothing" so only the active phase acts.
    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        ldPtrNext     = ldPtr;
        instNext      = instReg;
        instPcNext    = instPcReg;
        instValidNext = instValidReg;
        errNext       = errReg;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        halted        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = LOAD;
                end
            end

            LOAD: begin
                mem_addr  = ldPtr;
                mem_wdata = ld_data;
                if (ld_done) begin
                    stateNext = RUN;
                    pcNext    = RESET_PC;
                end else if (ld_valid) begin
                    if (ldInRange) begin
                        mem_we    = 1'b1;
                        ldPtrNext = ldPtr + WORD_STEP;
                    end else begin
                        errNext   = 1'b1;
                        stateNext = HALT;
                    end
                end
            end

            RUN: begin
                mem_addr = pc;
                if (redirect) begin
                    instValidNext = 1'b0;
                    if (redirectBad) begin
                        errNext   = 1'b1;
                        stateNext = HALT;
                    end else begin
                        pcNext = redirect_pc;
                    end
                end else if (bufferFree) begin
                    if (pcInRange) begin
                        instNext      = mem_rdata;
                        instPcNext    = pc;
                        instValidNext = 1'b1;
                        pcNext        = pc + WORD_STEP;
                    end else begin
                        instValidNext = 1'b0;
                        if (!instValidReg) begin
                            stateNext = HALT;
                        end
                    end
                end
            end

            HALT: begin
                halted = 1'b1;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            ldPtr        <= '0;
            instReg      <= '0;
            instPcReg    <= '0;
            instValidReg <= 1'b0;
            errReg       <= 1'b0;
        end else begin
            state        <= stateNext;
            pc           <= pcNext;
            ldPtr        <= ldPtrNext;
            instReg      <= instNext;
            instPcReg    <= instPcNext;
            instValidReg <= instValidNext;
            errReg       <= errNext;
        end
    end

endmodule
